// File: rtl/des_iter_if.sv
// Request/response bundle for the iterative DES core: one request channel
// (block, key, direction) and one result channel, each valid/ready.
interface des_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [63:0] m;
    logic [63:0] k;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] c;

    modport master (output in_valid, mode, m, k, out_ready,
                    input  in_ready, out_valid, c);
    modport slave  (input  in_valid, mode, m, k, out_ready,
                    output in_ready, out_valid, c);
endinterface

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt engine evaluating UNROLL Feistel rounds per
// clock, with a non-overlapped accept -> run -> deliver handshake.
module des_iter_core #(
    parameter int UNROLL = 1
) (
    input  logic       clk,
    input  logic       rst,
    des_iter_if.slave  bus
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("des_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
    end

    localparam int STEPS = 16 / UNROLL;

    // Permutation tables hold 1-based DES bit numbers, bit 1 being the MSB.
    localparam int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
        35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int e_t [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
        12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
        24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int p_t [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
        7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
        23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
        30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam logic [1:0] sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    // Indexed by {row, col} = {b1, b6, b2..b5} of each 6-bit group.
    localparam logic [3:0] sbox_t [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] o;
        for (int j = 0; j < 64; j++) o[63-j] = x[64-ip_t[j]];
        return o;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] o;
        for (int j = 0; j < 64; j++) o[63-j] = x[64-fp_t[j]];
        return o;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] o;
        for (int j = 0; j < 56; j++) o[55-j] = x[64-pc1_t[j]];
        return o;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] o;
        for (int j = 0; j < 48; j++) o[47-j] = x[56-pc2_t[j]];
        return o;
    endfunction

    function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] kk);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        for (int j = 0; j < 48; j++) x[47-j] = r[32-e_t[j]];
        x = x ^ kk;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = sbox_t[b][{six[5], six[0], six[4:1]}];
        end
        for (int j = 0; j < 32; j++) o[31-j] = s[32-p_t[j]];
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg;
    logic [31:0] l_reg, r_reg;
    logic [55:0] cd_reg;
    logic        mode_reg;
    logic [3:0]  cnt_reg;
    logic [63:0] c_reg;
    logic        out_valid_reg;
    logic        last;

    logic [31:0] l_s  [UNROLL+1];
    logic [31:0] r_s  [UNROLL+1];
    logic [55:0] cd_s [UNROLL+1];

    assign l_s[0]  = l_reg;
    assign r_s[0]  = r_reg;
    assign cd_s[0] = cd_reg;

    // Rounds chain combinationally; decrypt keys use CD before rotating it right.
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        logic [3:0]  rnd;
        logic [55:0] cd_rot;
        logic [55:0] cd_back;
        logic [47:0] kk;
        assign rnd     = 4'(int'(cnt_reg) * UNROLL + gi);
        assign cd_rot  = {rotl28(cd_s[gi][55:28], sh_t[rnd]), rotl28(cd_s[gi][27:0], sh_t[rnd])};
        assign cd_back = {rotr28(cd_s[gi][55:28], sh_t[4'd15 - rnd]),
                          rotr28(cd_s[gi][27:0], sh_t[4'd15 - rnd])};
        assign kk          = mode_reg ? pc2_f(cd_s[gi]) : pc2_f(cd_rot);
        assign cd_s[gi+1]  = mode_reg ? cd_back : cd_rot;
        assign l_s[gi+1]   = r_s[gi];
        assign r_s[gi+1]   = l_s[gi] ^ f_f(r_s[gi], kk);
    end

    assign last          = (cnt_reg == 4'(STEPS - 1));
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.c         = c_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            l_reg         <= '0;
            r_reg         <= '0;
            cd_reg        <= '0;
            mode_reg      <= 1'b0;
            cnt_reg       <= '0;
            c_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        {l_reg, r_reg} <= ip_f(bus.m);
                        cd_reg         <= pc1_f(bus.k);
                        mode_reg       <= bus.mode;
                        cnt_reg        <= '0;
                        state_reg      <= RUN;
                    end
                end
                RUN: begin
                    l_reg  <= l_s[UNROLL];
                    r_reg  <= r_s[UNROLL];
                    cd_reg <= cd_s[UNROLL];
                    if (last) begin
                        c_reg         <= fp_f({r_s[UNROLL], l_s[UNROLL]});
                        out_valid_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
